// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time (rise to fall) of an
// external PWM line in pwm_clk cycles, with a timeout for a static line.
module pwm_capture #(
  parameter int reg_width = 32,
  parameter int TIMEOUT   = 1048576
) (
  input  logic                 pwm_clk,
  input  logic                 pwm_rst,
  input  logic                 pwm_en,
  input  logic                 pwm_in,
  output logic [reg_width-1:0] pwm_period_out,
  output logic [reg_width-1:0] pwm_duty_out,
  output logic                 pwm_valid,
  output logic                 pwm_timeout,
  output logic                 pwm_level
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [reg_width-1:0] TMO = reg_width'(TIMEOUT);

  state_t               state, state_nxt;
  logic                 s1, s2, s3;
  logic [2:0]           vld_pipe;
  logic [reg_width-1:0] cnt, high_cnt;
  logic                 rise, fall, cnt_sat;
  logic                 ld_high, ld_res, tmo;

  // Synchronizer plus a fill marker: s2/s3 only reflect the real line once
  // vld_pipe[2] is set, so a line already high at reset release is not taken
  // for a low-to-high transition.
  always_ff @(posedge pwm_clk or posedge pwm_rst) begin
    if (pwm_rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1       <= pwm_in;
      s2       <= s1;
      s3       <= s2;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign cnt_sat   = (cnt == TMO);
  assign pwm_level = s2;

  always_ff @(posedge pwm_clk or posedge pwm_rst) begin
    if (pwm_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_high   = 1'b0;
    ld_res    = 1'b0;
    tmo       = 1'b0;
    if (!pwm_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (vld_pipe[2] && !s2) state_nxt = ARM;
        ARM:  if (rise) state_nxt = HIGH;
        HIGH: begin
          if (fall) begin
            ld_high   = 1'b1;
            state_nxt = LOW;
          end else if (cnt_sat && !rise) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
          end
        end
        LOW: begin
          // an edge landing on the saturation cycle wins over the timeout
          if (rise) begin
            ld_res    = 1'b1;
            state_nxt = HIGH;
          end else if (cnt_sat && !fall) begin
            tmo       = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // cnt restarts at 1 on the closing rise so consecutive periods are contiguous
  always_ff @(posedge pwm_clk or posedge pwm_rst) begin
    if (pwm_rst)                         cnt <= '0;
    else if (!pwm_en || state == IDLE)   cnt <= '0;
    else if (rise)                       cnt <= reg_width'(1);
    else if (state == ARM)               cnt <= '0;
    else if (!cnt_sat)                   cnt <= cnt + 1'b1;
  end

  always_ff @(posedge pwm_clk or posedge pwm_rst) begin
    if (pwm_rst) begin
      high_cnt       <= '0;
      pwm_period_out <= '0;
      pwm_duty_out   <= '0;
      pwm_valid      <= 1'b0;
      pwm_timeout    <= 1'b0;
    end else begin
      pwm_valid <= ld_res;
      if (ld_high) high_cnt <= cnt;
      if (ld_res) begin
        pwm_period_out <= cnt;
        pwm_duty_out   <= high_cnt;
        pwm_timeout    <= 1'b0;
      end else if (tmo) begin
        pwm_period_out <= '0;
        pwm_duty_out   <= '0;
        pwm_timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM waveforms on negedges and checks
// measured period/duty, valid latency, timeout, enable and async reset behaviour.
module tb_pwm_capture;

  logic        pwm_clk, pwm_rst, pwm_en, pwm_in;
  logic [31:0] pwm_period_out, pwm_duty_out;
  logic        pwm_valid, pwm_timeout, pwm_level;

  int n_chk, n_pass;
  int cyc, last_rise, nvalid;
  logic [31:0] last_p, last_d;
  logic prev_valid;

  pwm_capture #(.reg_width(32), .TIMEOUT(64)) dut (
    .pwm_clk(pwm_clk), .pwm_rst(pwm_rst), .pwm_en(pwm_en), .pwm_in(pwm_in),
    .pwm_period_out(pwm_period_out), .pwm_duty_out(pwm_duty_out),
    .pwm_valid(pwm_valid), .pwm_timeout(pwm_timeout), .pwm_level(pwm_level)
  );

  initial begin
    pwm_clk = 1'b0;
    forever #5 pwm_clk = ~pwm_clk;
  end

  always @(posedge pwm_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // every valid must land 3 edges after its closing rise and last one cycle
  always @(negedge pwm_clk) begin
    if (pwm_valid) begin
      nvalid++;
      last_p = pwm_period_out;
      last_d = pwm_duty_out;
      chk("valid_latency", 32'(cyc - last_rise), 32'd3);
      chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
    end
    prev_valid = pwm_valid;
  end

  task automatic rise_in();
    pwm_in    = 1'b1;
    last_rise = cyc;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      rise_in();
      repeat (hi) @(negedge pwm_clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge pwm_clk);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; last_rise = -100; nvalid = 0;
    prev_valid = 1'b0; last_p = '0; last_d = '0;
    pwm_rst = 1'b1; pwm_en = 1'b0; pwm_in = 1'b0;

    // reset state
    repeat (2) @(negedge pwm_clk);
    chk("rst_period", pwm_period_out, 32'd0);
    chk("rst_duty", pwm_duty_out, 32'd0);
    chk("rst_valid", {31'd0, pwm_valid}, 32'd0);
    chk("rst_timeout", {31'd0, pwm_timeout}, 32'd0);
    chk("rst_level", {31'd0, pwm_level}, 32'd0);

    // continuous 3/7 waveform: 6 rises give 5 results of 10/3
    pwm_rst = 1'b0; pwm_en = 1'b1;
    repeat (5) @(negedge pwm_clk);
    wave(3, 7, 6);
    chk("t1_nvalid", nvalid, 32'd5);
    chk("t1_period", last_p, 32'd10);
    chk("t1_duty", last_d, 32'd3);
    chk("t1_timeout", {31'd0, pwm_timeout}, 32'd0);

    // line high through reset release must not produce a result
    nvalid = 0;
    pwm_rst = 1'b1; pwm_in = 1'b1;
    repeat (2) @(negedge pwm_clk);
    chk("t2_rst_period", pwm_period_out, 32'd0);
    pwm_rst = 1'b0;
    repeat (6) @(negedge pwm_clk);
    chk("t2_level_high", {31'd0, pwm_level}, 32'd1);
    pwm_in = 1'b0;
    repeat (6) @(negedge pwm_clk);
    chk("t2_no_valid", nvalid, 32'd0);
    wave(8, 12, 3);
    chk("t2_nvalid", nvalid, 32'd2);
    chk("t2_period", last_p, 32'd20);
    chk("t2_duty", last_d, 32'd8);

    // stuck low: timeout after 64 cycles without an edge
    repeat (40) @(negedge pwm_clk);
    chk("t3_no_early_tmo", {31'd0, pwm_timeout}, 32'd0);
    repeat (30) @(negedge pwm_clk);
    chk("t3_timeout", {31'd0, pwm_timeout}, 32'd1);
    chk("t3_period_zero", pwm_period_out, 32'd0);
    chk("t3_duty_zero", pwm_duty_out, 32'd0);
    chk("t3_level", {31'd0, pwm_level}, 32'd0);
    nvalid = 0;
    wave(5, 5, 3);
    chk("t3_nvalid", nvalid, 32'd2);
    chk("t3_period", last_p, 32'd10);
    chk("t3_duty", last_d, 32'd5);
    chk("t3_tmo_cleared", {31'd0, pwm_timeout}, 32'd0);

    // period exactly TIMEOUT: edge coincides with saturation and wins
    nvalid = 0;
    wave(20, 44, 3);
    chk("t4_nvalid", nvalid, 32'd3);
    chk("t4_period", last_p, 32'd64);
    chk("t4_duty", last_d, 32'd20);
    chk("t4_no_timeout", {31'd0, pwm_timeout}, 32'd0);

    // async reset while HIGH
    wave(4, 6, 3);
    chk("t5_pre_period", pwm_period_out, 32'd10);
    rise_in();
    repeat (4) @(negedge pwm_clk);
    #2 pwm_rst = 1'b1;
    #1;
    chk("t5_async_period", pwm_period_out, 32'd0);
    chk("t5_async_duty", pwm_duty_out, 32'd0);
    chk("t5_async_valid", {31'd0, pwm_valid}, 32'd0);
    @(negedge pwm_clk);
    pwm_rst = 1'b0;
    nvalid = 0;
    repeat (5) @(negedge pwm_clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge pwm_clk);
    wave(4, 6, 1);
    chk("t5_no_valid_1st", nvalid, 32'd0);
    wave(4, 6, 1);
    chk("t5_nvalid", nvalid, 32'd1);
    chk("t5_period", last_p, 32'd10);
    chk("t5_duty", last_d, 32'd4);

    // enable dropped mid-LOW: partial period discarded, outputs held
    wave(6, 9, 2);
    rise_in();
    repeat (4) @(negedge pwm_clk);
    pwm_in = 1'b0;
    repeat (4) @(negedge pwm_clk);
    chk("t6_pre_period", pwm_period_out, 32'd15);
    nvalid = 0;
    pwm_en = 1'b0;
    repeat (3) @(negedge pwm_clk);
    chk("t6_hold_period", pwm_period_out, 32'd15);
    chk("t6_hold_duty", pwm_duty_out, 32'd6);
    pwm_en = 1'b1;
    repeat (3) @(negedge pwm_clk);
    wave(4, 6, 2);
    chk("t6_nvalid", nvalid, 32'd1);
    chk("t6_period", last_p, 32'd10);
    chk("t6_duty", last_d, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
